// File: rtl/ecdsa_pkg.sv
// Shared definitions for the ECDSA datapath: field width, the secp256k1 prime,
// and the control state encoding used by the iterative arithmetic blocks.
package ecdsa_pkg;

  localparam int unsigned FIELD_W = 256;

  localparam logic [FIELD_W-1:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_mul_step.sv
// One MSB-first interleaved step: R' = ((2R mod p) + bit*a) mod p, with R < p.
// Kept combinational and standalone so it can be unit tested or pipelined later.
module mod_mul_step
  import ecdsa_pkg::*;
#(
  parameter int unsigned n = FIELD_W
) (
  input  logic [n-1:0] r_i,
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] p_i,
  input  logic         bit_i,
  output logic [n-1:0] r_o
);

  // One extra bit of headroom: every intermediate value stays below 2p.
  logic [n:0] p_ext;
  logic [n:0] dbl;
  logic [n:0] dbl_red;
  logic [n:0] sum;
  logic [n:0] sum_red;

  assign p_ext   = {1'b0, p_i};
  assign dbl     = {r_i, 1'b0};
  assign dbl_red = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
  assign sum     = bit_i ? (dbl_red + {1'b0, a_i}) : dbl_red;
  assign sum_red = (sum >= p_ext) ? (sum - p_ext) : sum;
  assign r_o     = sum_red[n-1:0];

endmodule

// File: rtl/modular_multiplier.sv
// Iterative modular multiplier: result = (a * b) mod p, one bit of b per clock,
// start/busy/done handshake with a fixed latency of n+1 cycles from start.
module modular_multiplier
  import ecdsa_pkg::*;
#(
  parameter int unsigned n = FIELD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(n - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  r_q, r_d;
  logic [n-1:0]  res_q, res_d;
  logic [n-1:0]  p_q, p_d;
  logic [n-1:0]  a_q, a_d;
  logic [n-1:0]  b_q, b_d;
  logic [n-1:0]  r_step;

  mod_mul_step #(.n(n)) u_step (
    .r_i  (r_q),
    .a_i  (a_q),
    .p_i  (p_q),
    .bit_i(b_q[cnt_q]),
    .r_o  (r_step)
  );

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      res_q   <= res_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    p_q <= p_d;
    a_q <= a_d;
    b_q <= b_d;
  end

  // NOTE: every always_comb output gets a default first, so no latch can form.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    res_d   = res_q;
    p_d     = p_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          p_d     = p;
          a_d     = a;
          b_d     = b;
          r_d     = '0;
          cnt_d   = CNT_TOP;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        r_d = r_step;
        if (cnt_q == '0) begin
          res_d   = r_step;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // Start is not looked at here; a request must wait for IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign result = res_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_modular_multiplier.sv
// Self-checking bench: n=8 directed table and corner sequences, n=256 secp256k1
// checks, n=16 randomised operands against a plain-arithmetic (a*b)%p model.
module tb_modular_multiplier;
  import ecdsa_pkg::*;

  logic         clk;
  logic         reset;
  logic [2:0]   start_v;
  logic [255:0] p_drv, a_drv, b_drv;

  logic [7:0]   r8;
  logic [15:0]  r16;
  logic [255:0] r256;
  logic         busy8, busy16, busy256;
  logic         done8, done16, done256;

  int total = 0;
  int bad   = 0;
  logic [255:0] last_exp [3];

  modular_multiplier #(.n(8)) u8 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .p(p_drv[7:0]), .a(a_drv[7:0]), .b(b_drv[7:0]),
    .result(r8), .busy(busy8), .done(done8)
  );

  modular_multiplier #(.n(16)) u16 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .p(p_drv[15:0]), .a(a_drv[15:0]), .b(b_drv[15:0]),
    .result(r16), .busy(busy16), .done(done16)
  );

  modular_multiplier #(.n(256)) u256 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .p(p_drv), .a(a_drv), .b(b_drv),
    .result(r256), .busy(busy256), .done(done256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    case (sel)
      0:       return 8;
      1:       return 16;
      default: return 256;
    endcase
  endfunction

  function automatic logic [255:0] res_of(input int sel);
    case (sel)
      0:       return 256'(r8);
      1:       return 256'(r16);
      default: return r256;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy8;
      1:       return busy16;
      default: return busy256;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done8;
      1:       return done16;
      default: return done256;
    endcase
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // Full transaction: start in cycle T, done expected exactly at T+w+1.
  task automatic run_op(input int sel, input logic [255:0] pv, input logic [255:0] av,
                        input logic [255:0] bv, input logic [255:0] ev, input string nm);
    int w, done_at, done_cnt, busy_bad;
    w = width_of(sel);
    done_at = -1; done_cnt = 0; busy_bad = 0;
    @(negedge clk);
    p_drv = pv; a_drv = av; b_drv = bv;
    start_v[sel] = 1'b1;
    for (int k = 1; k <= w + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_v[sel] = 1'b0;
        p_drv = rand256(); a_drv = rand256(); b_drv = rand256();
        check({nm, " held during run"}, res_of(sel), last_exp[sel]);
      end
      if (done_of(sel)) begin
        done_cnt++;
        done_at = k;
      end
      if (busy_of(sel) != (k <= w)) busy_bad++;
      if (k == w + 1) check({nm, " result"}, res_of(sel), ev);
    end
    check({nm, " done cycle"}, 256'(done_at), 256'(w + 1));
    check({nm, " done pulses"}, 256'(done_cnt), 256'd1);
    check({nm, " busy window errors"}, 256'(busy_bad), 256'd0);
    last_exp[sel] = ev;
  endtask

  typedef struct {
    logic [7:0] p;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [256:0] half;
    logic [255:0] av, bv, ev;
    logic [15:0]  p16, a16, b16;
    int           done_seen;

    tbl[0] = '{8'd13,  8'd7,   8'd10,  8'd5,   "p13 7x10"};
    tbl[1] = '{8'd23,  8'd5,   8'd14,  8'd1,   "p23 inverse"};
    tbl[2] = '{8'd23,  8'd22,  8'd22,  8'd1,   "p23 minus1 sq"};
    tbl[3] = '{8'd23,  8'd5,   8'd0,   8'd0,   "p23 b zero"};
    tbl[4] = '{8'd23,  8'd0,   8'd17,  8'd0,   "p23 a zero"};
    tbl[5] = '{8'd2,   8'd1,   8'd255, 8'd1,   "p2 b max"};
    tbl[6] = '{8'd251, 8'd250, 8'd255, 8'd247, "p251 wide"};
    tbl[7] = '{8'd255, 8'd254, 8'd254, 8'd1,   "p255 minus1 sq"};

    reset = 1'b1; start_v = '0;
    p_drv = '0; a_drv = '0; b_drv = '0;
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    repeat (2) @(negedge clk);
    check("reset result8", res_of(0), 256'd0);
    check("reset busy8", 256'(busy8), 256'd0);
    check("reset done8", 256'(done8), 256'd0);
    check("reset result256", res_of(2), 256'd0);
    check("reset busy256", 256'(busy256), 256'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(0, 256'(tbl[i].p), 256'(tbl[i].a), 256'(tbl[i].b), 256'(tbl[i].exp), tbl[i].nm);

    // Restarts during RUN and DONE are dropped; the first IDLE start is taken.
    @(negedge clk);
    p_drv = 256'd13; a_drv = 256'd7; b_drv = 256'd10; start_v[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("restart done k=%0d", k), 256'(done8), 256'(k == 9 || k == 19));
      check($sformatf("restart busy k=%0d", k), 256'(busy8),
            256'((k >= 1 && k <= 8) || (k >= 11 && k <= 18)));
      if (k == 9 || k == 19)
        check($sformatf("restart result k=%0d", k), res_of(0), (k == 9) ? 256'd5 : 256'd12);
      case (k)
        1:  start_v[0] = 1'b0;
        3:  begin p_drv = 256'd11; a_drv = 256'd1; b_drv = 256'd1; start_v[0] = 1'b1; end
        4:  start_v[0] = 1'b0;
        9:  begin p_drv = 256'd7;  a_drv = 256'd2; b_drv = 256'd2; start_v[0] = 1'b1; end
        10: begin p_drv = 256'd13; a_drv = 256'd3; b_drv = 256'd4; start_v[0] = 1'b1; end
        11: start_v[0] = 1'b0;
        default: ;
      endcase
    end
    last_exp[0] = 256'd12;

    // Reset in the middle of a run abandons it with no done pulse.
    @(negedge clk);
    p_drv = 256'd13; a_drv = 256'd7; b_drv = 256'd10; start_v[0] = 1'b1;
    done_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start_v[0] = 1'b0;
      if (k == 4) reset = 1'b1;
      if (k == 5) begin
        check("midrst result", res_of(0), 256'd0);
        check("midrst busy", 256'(busy8), 256'd0);
        check("midrst done", 256'(done8), 256'd0);
        check("midrst state", 256'(u8.state_q), 256'(ST_IDLE));
        reset = 1'b0;
      end
      if (k > 5 && done8) done_seen++;
    end
    check("midrst no late done", 256'(done_seen), 256'd0);
    last_exp[0] = '0;
    run_op(0, 256'd13, 256'd7, 256'd10, 256'd5, "after reset");

    // Start coinciding with reset must not be accepted.
    @(negedge clk);
    reset = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0; start_v[0] = 1'b0;
    check("start with reset busy", 256'(busy8), 256'd0);
    @(negedge clk);
    check("start with reset still idle", 256'(busy8), 256'd0);
    last_exp[0] = '0;

    // secp256k1: 2 * (p+1)/2 = 1, and (p-1)^2 = 1.
    half = ({1'b0, SECP256K1_P} + 257'd1) >> 1;
    run_op(2, SECP256K1_P, 256'd2, half[255:0], 256'd1, "k1 two x half");
    run_op(2, SECP256K1_P, SECP256K1_P - 256'd1, SECP256K1_P - 256'd1, 256'd1, "k1 minus1 sq");
    av = rand256() % SECP256K1_P;
    bv = rand256();
    ev = 256'((512'(av) * 512'(bv)) % 512'(SECP256K1_P));
    run_op(2, SECP256K1_P, av, bv, ev, "k1 random");

    for (int i = 0; i < 30; i++) begin
      p16 = 16'($urandom_range(65535, 2));
      a16 = 16'($urandom % 32'(p16));
      b16 = 16'($urandom);
      if (i == 0) b16 = 16'hFFFF;
      run_op(1, 256'(p16), 256'(a16), 256'(b16),
             256'((32'(a16) * 32'(b16)) % 32'(p16)), $sformatf("rand16 #%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
